ct_spsram_param: RTL and testbench
==================================

Name: ct_spsram_param

Overview:
- Parametrised single-port SRAM wrapper. Next generation of the fixed-size CPU SRAM wrappers; one module covers every depth, width and write-enable granularity.
- Adds three things the fixed wrappers lack: a hardware clear sweep after reset, an optional output pipeline register, and a read-data valid strobe.
- Sits under cache tag/data/dirty array tops. The behavioural array is the FPGA/simulation model; the foundry macro is substituted at the same boundary.

Parameters:
- ADDR_WIDTH, 8: address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 23: data bits per word.
- WE_WIDTH, 23: write-enable bits. Must divide DATA_WIDTH. Each WEN bit covers G = DATA_WIDTH/WE_WIDTH data bits.
- OUT_REG, 0: 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.
- INIT_ON_RST, 1: 1 = clear sweep after reset; 0 = no sweep.
- INIT_VALUE, 0: DATA_WIDTH-bit value written to every word by the sweep.

Ports:
- CLK, input, 1: clock; all logic on the rising edge.
- RST, input, 1: reset, synchronous, active-high.
- A, input, ADDR_WIDTH: word address.
- CEN, input, 1: chip enable, active-low.
- GWEN, input, 1: global write enable, active-low. 0 = write, 1 = read.
- WEN, input, WE_WIDTH: per-group write enable, active-low.
- D, input, DATA_WIDTH: write data.
- Q, output, DATA_WIDTH: read data.
- Q_VLD, output, 1: one-cycle pulse when Q carries newly read data.
- BUSY, output, 1: clear sweep in progress; all accesses are ignored while high.

Behaviour:
- Access condition: CEN=0 and BUSY=0, sampled at the rising edge.
- Write (access with GWEN=0): for each i where WEN[i]=0, mem[A][i*G +: G] <= D[i*G +: G]. Groups with WEN[i]=1 keep their contents. WEN all-ones = no-op write.
- Write cycle effect on outputs: Q holds its value and Q_VLD=0. There is no write-through.
- Read (access with GWEN=1):
  - OUT_REG=0: Q <= mem[A] and Q_VLD=1 on the next edge.
  - OUT_REG=1: data passes through a second register; Q and Q_VLD appear one cycle later.
  - Back-to-back reads stream at one read per cycle.
- Q holds its last value whenever no new read data arrives. Q_VLD is 0 in those cycles.
- Read after write to the same address on the next cycle returns the new data.
- WEN and D are don't-care on reads. A, D, GWEN and WEN are don't-care when CEN=1.
- Reset (RST=1 at an edge): Q=0, Q_VLD=0. The pipeline register is cleared and in-flight reads are dropped.
  - INIT_ON_RST=1: FSM enters INIT, cnt=0, BUSY=1.
  - INIT_ON_RST=0: FSM enters IDLE, BUSY=0. Array contents are unchanged by reset (X in simulation at power-up).
- FSM states are IDLE and INIT.
  - INIT: each cycle mem[cnt] <= INIT_VALUE and cnt <= cnt+1. When cnt = DEPTH-1 the last word is written and the FSM goes to IDLE; BUSY falls at that edge.
  - Sweep length is exactly DEPTH cycles from the first non-reset edge. BUSY is 1 for DEPTH cycles.
  - IDLE: stays in IDLE until the next RST.
- Reset held across several cycles: FSM stays in INIT with cnt=0, and no word is written while RST=1.
- RST asserted mid-sweep: cnt restarts at 0 and the sweep reruns in full.
- cnt is ADDR_WIDTH wide and never wraps within a sweep.
- Requests with CEN=0 during BUSY are dropped silently: no write, no Q_VLD. The requester must hold off until BUSY=0.
- A request in the cycle BUSY falls (first cycle with BUSY=0) is accepted normally.
- Out-of-range address is impossible, since DEPTH = 2**ADDR_WIDTH.

Test Plan:
- Defaults; RST for 1 cycle. Required: BUSY=1 for exactly 256 cycles. Then reading addresses 0, 128, 255 gives Q=23'h0 with Q_VLD one cycle after each request.
- Write A=8'h10, D=23'h7FFFFF, WEN all-zero; next cycle read A=8'h10. Required: Q=23'h7FFFFF, Q_VLD=1 one cycle after the read; Q unchanged during the write cycle.
- Partial write to A=8'h10 with D=0, WEN=23'h7FFF00 (low 8 groups enabled), after the write above. Required: read returns 23'h7FFF00.
- OUT_REG=1; reads of A=1,2,3 on consecutive cycles after writing 5, 6, 7 there. Required: Q=5,6,7 with Q_VLD high on cycles t+2, t+3, t+4.
- Assert RST at sweep cycle 100; issue a write during BUSY. Required: BUSY stays high 256 cycles after reset release, the write is dropped, and the whole array reads INIT_VALUE.
- WE_WIDTH=1, DATA_WIDTH=64, ADDR_WIDTH=4, INIT_ON_RST=0. Required: BUSY=0 right after reset, and a full-word write/read to A=15 round-trips 64'hDEADBEEF_CAFEF00D.

Source files
------------

// File: rtl/ct_spsram_param.sv
// Parametrised single-port SRAM wrapper: byte/bit-group write enables, post-reset
// clear sweep, optional output pipeline register and a read-data valid strobe.
module ct_spsram_param #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 23,
  parameter int                    WE_WIDTH    = 23,
  parameter int                    OUT_REG     = 0,
  parameter int                    INIT_ON_RST = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VLD,
  output logic                  BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int G     = DATA_WIDTH / WE_WIDTH;

  typedef enum logic {IDLE, INIT} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    busy;
  logic                    acc;
  logic                    rd_acc;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_mask;

  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_vld_q, rd_vld_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= (INIT_ON_RST != 0) ? INIT : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (&cnt_q) state_d = IDLE;
    end
  end

  always_comb begin
    busy = (state_q == INIT);
  end

  assign BUSY   = busy;
  assign acc    = !CEN && !busy && !RST;
  assign rd_acc = acc && GWEN;

  // The sweep owns the array port while busy; user requests are dropped then.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = A;
    mem_wdata = D;
    mem_mask  = '0;
    if (!RST && busy) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = INIT_VALUE;
      mem_mask  = '1;
    end else if (acc && !GWEN) begin
      mem_we = 1'b1;
      for (int i = 0; i < WE_WIDTH; i++) begin
        mem_mask[i*G +: G] = {G{~WEN[i]}};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_addr] <= (mem_q[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
    end
  end

  always_comb begin
    rd_data_d = rd_acc ? mem_q[A] : rd_data_q;
    rd_vld_d  = rd_acc;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  // Optional second stage holds its data until a new read word passes through.
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_vld_q, out_vld_d;

    always_comb begin
      out_data_d = rd_vld_q ? rd_data_q : out_data_q;
      out_vld_d  = rd_vld_q;
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        out_data_q <= '0;
        out_vld_q  <= 1'b0;
      end else begin
        out_data_q <= out_data_d;
        out_vld_q  <= out_vld_d;
      end
    end

    assign Q     = out_data_q;
    assign Q_VLD = out_vld_q;
  end else begin : g_no_out_reg
    assign Q     = rd_data_q;
    assign Q_VLD = rd_vld_q;
  end

endmodule

// File: tb/tb_ct_spsram_param.sv
// Directed bench for ct_spsram_param: default, output-registered and wide
// single-enable/no-sweep configurations driven side by side from one sequence.
module tb_ct_spsram_param;

  logic        clk = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // u0: defaults
  logic        rst0;
  logic [7:0]  a0;
  logic        cen0, gwen0;
  logic [22:0] wen0, d0, q0;
  logic        vld0, busy0;

  // u1: output register
  logic        rst1;
  logic [7:0]  a1;
  logic        cen1, gwen1;
  logic [22:0] wen1, d1, q1;
  logic        vld1, busy1;

  // u2: 64-bit, single write enable, no sweep
  logic        rst2;
  logic [3:0]  a2;
  logic        cen2, gwen2;
  logic [0:0]  wen2;
  logic [63:0] d2, q2;
  logic        vld2, busy2;

  int          n;

  always #5 clk = ~clk;

  ct_spsram_param u0 (
    .CLK(clk), .RST(rst0), .A(a0), .CEN(cen0), .GWEN(gwen0), .WEN(wen0),
    .D(d0), .Q(q0), .Q_VLD(vld0), .BUSY(busy0)
  );

  ct_spsram_param #(.OUT_REG(1)) u1 (
    .CLK(clk), .RST(rst1), .A(a1), .CEN(cen1), .GWEN(gwen1), .WEN(wen1),
    .D(d1), .Q(q1), .Q_VLD(vld1), .BUSY(busy1)
  );

  ct_spsram_param #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .WE_WIDTH(1), .INIT_ON_RST(0)) u2 (
    .CLK(clk), .RST(rst2), .A(a2), .CEN(cen2), .GWEN(gwen2), .WEN(wen2),
    .D(d2), .Q(q2), .Q_VLD(vld2), .BUSY(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one request onto u0; cen=1 parks the port.
  task automatic applyStimulus(input logic cen, input logic gwen, input logic [7:0] addr,
                               input logic [22:0] wen, input logic [22:0] data);
    cen0  = cen;
    gwen0 = gwen;
    a0    = addr;
    wen0  = wen;
    d0    = data;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h00, '1, '0);
    cen1 = 1'b1; gwen1 = 1'b1; a1 = '0; wen1 = '1; d1 = '0;
    cen2 = 1'b1; gwen2 = 1'b1; a2 = '0; wen2 = '1; d2 = '0;
    tick();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    checkOutput("rst_q0", 64'(q0), 64'h0);
    checkOutput("rst_vld0", 64'(vld0), 64'h0);
    checkOutput("rst_q1", 64'(q1), 64'h0);
    checkOutput("rst_busy2", 64'(busy2), 64'h0);
    checkOutput("rst_q2_vld", 64'(vld2), 64'h0);

    n = 0;
    while (busy0 === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("sweep_len", 64'(n), 64'd256);
    checkOutput("busy1_done", 64'(busy1), 64'h0);

    foreach (a0[i]) begin end
    for (int k = 0; k < 3; k++) begin
      logic [7:0] addr;
      addr = (k == 0) ? 8'd0 : (k == 1) ? 8'd128 : 8'd255;
      applyStimulus(1'b0, 1'b1, addr, '1, '0);
      tick();
      applyStimulus(1'b1, 1'b1, 8'h00, '1, '0);
      checkOutput("init_rd_q", 64'(q0), 64'h0);
      checkOutput("init_rd_vld", 64'(vld0), 64'h1);
    end
    tick();
    checkOutput("vld_drop", 64'(vld0), 64'h0);

    applyStimulus(1'b0, 1'b0, 8'h10, 23'h0, 23'h7FFFFF);
    tick();
    checkOutput("wr_q_hold", 64'(q0), 64'h0);
    checkOutput("wr_vld", 64'(vld0), 64'h0);
    applyStimulus(1'b0, 1'b1, 8'h10, '1, '0);
    tick();
    applyStimulus(1'b1, 1'b1, 8'h00, '1, '0);
    checkOutput("raw_q", 64'(q0), 64'h7FFFFF);
    checkOutput("raw_vld", 64'(vld0), 64'h1);

    applyStimulus(1'b0, 1'b0, 8'h10, 23'h7FFF00, 23'h0);
    tick();
    checkOutput("pwr_q_hold", 64'(q0), 64'h7FFFFF);
    checkOutput("pwr_vld", 64'(vld0), 64'h0);
    applyStimulus(1'b0, 1'b1, 8'h10, '1, '0);
    tick();
    checkOutput("pwr_rd", 64'(q0), 64'h7FFF00);

    applyStimulus(1'b0, 1'b0, 8'h10, '1, 23'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h10, '1, '0);
    tick();
    applyStimulus(1'b1, 1'b1, 8'h00, '1, '0);
    checkOutput("noop_wr", 64'(q0), 64'h7FFF00);

    // Output-registered pipeline on u1
    for (int k = 1; k <= 3; k++) begin
      cen1 = 1'b0; gwen1 = 1'b0; a1 = 8'(k); wen1 = '0; d1 = 23'(k + 4);
      tick();
    end
    checkOutput("or_wr_vld", 64'(vld1), 64'h0);
    cen1 = 1'b0; gwen1 = 1'b1; a1 = 8'd1;
    tick();
    checkOutput("or_lat1_vld", 64'(vld1), 64'h0);
    a1 = 8'd2;
    tick();
    checkOutput("or_q5", 64'(q1), 64'd5);
    checkOutput("or_v5", 64'(vld1), 64'h1);
    a1 = 8'd3;
    tick();
    cen1 = 1'b1;
    checkOutput("or_q6", 64'(q1), 64'd6);
    checkOutput("or_v6", 64'(vld1), 64'h1);
    tick();
    checkOutput("or_q7", 64'(q1), 64'd7);
    checkOutput("or_v7", 64'(vld1), 64'h1);
    tick();
    checkOutput("or_hold_q", 64'(q1), 64'd7);
    checkOutput("or_hold_vld", 64'(vld1), 64'h0);

    // Wide config: full-word round trip at the top address
    cen2 = 1'b0; gwen2 = 1'b0; a2 = 4'hF; wen2 = 1'b0; d2 = 64'hDEADBEEF_CAFEF00D;
    tick();
    gwen2 = 1'b1; d2 = '0;
    tick();
    cen2 = 1'b1;
    checkOutput("wide_q", q2, 64'hDEADBEEF_CAFEF00D);
    checkOutput("wide_vld", 64'(vld2), 64'h1);

    // Mid-sweep reset on u0, then a write and read while busy
    applyStimulus(1'b0, 1'b0, 8'd200, '0, 23'h123);
    tick();
    applyStimulus(1'b1, 1'b1, 8'h00, '1, '0);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    checkOutput("mid_busy", 64'(busy0), 64'h1);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    checkOutput("rerst_q", 64'(q0), 64'h0);
    n = 0;
    while (busy0 === 1'b1 && n < 1000) begin
      if (n == 10) applyStimulus(1'b0, 1'b0, 8'd5, '0, 23'h7FFFFF);
      else if (n == 20) applyStimulus(1'b0, 1'b1, 8'd0, '1, '0);
      else applyStimulus(1'b1, 1'b1, 8'h00, '1, '0);
      tick();
      n++;
      if (n == 21) checkOutput("busy_rd_vld", 64'(vld0), 64'h0);
    end
    checkOutput("resweep_len", 64'(n), 64'd256);

    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b0, 1'b1, 8'(k), '1, '0);
      tick();
      checkOutput($sformatf("sweep_rd_%0d", k), {31'h0, vld0, 9'h0, q0}, {31'h0, 1'b1, 9'h0, 23'h0});
    end
    applyStimulus(1'b1, 1'b1, 8'h00, '1, '0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
